matriz_operand_feeder: RTL and testbench
========================================

# matriz_operand_feeder

Producer side of the multiply-accumulate interface: holds an M×N matrix and an N-element column vector, and streams operand pairs (k, l) to the MAC one row at a time. Each row is framed with `first`/`last` so the MAC clears its sum at each row start and presents one dot product per row. It sits between the host write port and the MAC, turning matrix-vector products into a valid/ready operand stream.

## Interface
- W, 11, operand width in bits (k and l)
- N, 4, vector length / matrix columns
- M, 4, matrix rows
- clock  in  1  single system clock, rising edge
- reset  in  1  asynchronous, active-low; 0 forces reset state immediately
- wr_en  in  1  load strobe for operand storage
- wr_sel  in  1  0 = matrix, 1 = vector
- wr_addr  in  clog2(M*N)  matrix: row*N + col; vector: element index
- wr_data  in  W  value written
- start  in  1  begin streaming (sampled only in IDLE)
- busy  out  1  high in STREAM
- done  out  1  one-cycle pulse after final pair accepted
- pair_valid  out  1  k/l/first/last/row valid
- pair_ready  in  1  MAC accepts pair when high with pair_valid
- k  out  W  A[row][col]
- l  out  W  x[col]
- first  out  1  col == 0; MAC must clear sum before adding
- last  out  1  col == N-1; MAC sum complete after this pair
- row  out  clog2(M)  current row index

## Operation
- FSM states: IDLE, STREAM, DONE.
- IDLE: pair_valid=0, busy=0. start=1 -> STREAM, row=0, col=0.
- STREAM: pair_valid=1; k=A[row][col], l=x[col]. On pair_valid && pair_ready: col+1; col wraps N-1 -> 0 with row+1. Transfer at row=M-1, col=N-1 -> DONE.
- DONE: done=1 for exactly one cycle, pair_valid=0 -> IDLE.
- Handshake: while pair_valid=1 and pair_ready=0, k, l, first, last and row hold stable. pair_valid never drops mid-stream.
- Writes: accepted only in IDLE. wr_en in STREAM/DONE ignored. Matrix addr >= M*N or vector addr >= N: ignored, no side effects.
- start in STREAM/DONE ignored. start and wr_en in the same IDLE cycle: write lands; stream begins next cycle using the new value.
- Arithmetic (consumer rule): product is 2W bits; row sum needs 2W+clog2(N) bits. With defaults that is 24 bits, so a 21-bit accumulator is insufficient.
- Reset (any state, including mid-stream): FSM -> IDLE; counters, storage and all outputs -> 0. Partial row is abandoned and the MAC sees no further pairs.

## Timing
- Reset values: busy=0, done=0, pair_valid=0, k=0, l=0, first=0, last=0, row=0.
- All outputs registered. start in IDLE at cycle t -> pair_valid=1 with A[0][0], x[0], first=1 at t+1.
- With pair_ready held high: one pair per cycle, M*N pairs, last pair at t+M*N, done at t+M*N+1, IDLE (accepts start) at t+M*N+2.
- Each stall cycle (pair_ready=0) adds exactly one cycle.
- Write at cycle t is readable by a stream started at t or later.

## Structure
- Shared package `matriz_pkg`:
  - default W/N/M constants
  - FSM state enum {IDLE, STREAM, DONE}
  - address-width constants
- Sub-module `matriz_store`:
  - M*N + N register file with one write port and a combinational read of A[row][col] and x[col]
  - async active-low clear
- Top holds the FSM, counters and output registers.

## Test plan
- Load A = 1..16 row-major, x = {1,2,3,4}; start with ready=1 -> pairs (1,1),(2,2),(3,3),(4,4),(5,1)...; first on pairs 0,4,8,12; last on 3,7,11,15; reference MAC rows = 30,70,110,150; done 17 cycles after start.
- Same stream, pair_ready toggled 1/0 each cycle -> identical pair sequence, outputs stable during stalls, done at cycle 33.
- A all 2047, x all 2047, ready=1 -> each row sum = 16,760,836, which fits in 24 bits.
- wr_en in STREAM writing A[0][0]=99 -> ignored; a second run still emits 1 first. Write to vector addr 5 in IDLE -> no change.
- Reset low at pair 6 -> pair_valid=0 immediately and storage reads 0. After release, start -> all pairs (0,0), done at 17.
- start pulsed during STREAM and DONE -> no restart; exactly 16 transfers and one done pulse.

Source files
------------

// File: rtl/matriz_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : matriz_pkg
//  Purpose  : Shared constants, width helpers and FSM state type for the
//             matrix-vector operand feeder and its operand store.
//  Contents : default W/N/M, address widths, state_e {IDLE, STREAM, DONE}
//  Revision : 1.0  initial release
// ============================================================================
package matriz_pkg;

   localparam int W_DEF = 11;   // operand width (k and l)
   localparam int N_DEF = 4;    // vector length / matrix columns
   localparam int M_DEF = 4;    // matrix rows

   // Index widths never collapse to zero bits, even for a 1-row/1-column setup.
   function automatic int clog2_min1(input int v);
      return (v <= 2) ? 1 : $clog2(v);
   endfunction

   localparam int ADDR_W_DEF = clog2_min1(M_DEF * N_DEF);
   localparam int ROW_W_DEF  = clog2_min1(M_DEF);
   localparam int COL_W_DEF  = clog2_min1(N_DEF);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_STREAM = 2'd1,
      ST_DONE   = 2'd2
   } state_e;

endpackage
`default_nettype wire

// File: rtl/matriz_store.sv
`default_nettype none
// ============================================================================
//  Module   : matriz_store
//  Purpose  : Register file holding the M x N matrix A (row-major) and the
//             N-element vector x. One write port, combinational read of
//             A[rd_row][rd_col] and x[rd_col]. Cleared by async reset.
//  Ports    : i_we/i_wr_sel/i_wr_addr/i_wr_data  write port (sel 0=A, 1=x)
//             i_rd_row/i_rd_col                  read index
//             o_rd_k/o_rd_l                      A[row][col], x[col]
//  Revision : 1.0  initial release
// ============================================================================
module matriz_store
   import matriz_pkg::*;
#(
   parameter int W      = W_DEF,
   parameter int N      = N_DEF,
   parameter int M      = M_DEF,
   parameter int ADDR_W = clog2_min1(M * N),
   parameter int ROW_W  = clog2_min1(M),
   parameter int COL_W  = clog2_min1(N)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_we,
   input  logic              i_wr_sel,
   input  logic [ADDR_W-1:0] i_wr_addr,
   input  logic [W-1:0]      i_wr_data,
   input  logic [ROW_W-1:0]  i_rd_row,
   input  logic [COL_W-1:0]  i_rd_col,
   output logic [W-1:0]      o_rd_k,
   output logic [W-1:0]      o_rd_l
);

   logic [W-1:0] mat_q [M*N];
   logic [W-1:0] mat_d [M*N];
   logic [W-1:0] vec_q [N];
   logic [W-1:0] vec_d [N];

   logic              w_mat_wr;
   logic              w_vec_wr;
   logic [ADDR_W-1:0] w_rd_idx;

   // Out-of-range addresses are dropped here so they can never alias.
   always_comb begin
      w_mat_wr = i_we && !i_wr_sel && (int'(i_wr_addr) < M * N);
      w_vec_wr = i_we &&  i_wr_sel && (int'(i_wr_addr) < N);
   end

   always_comb begin
      mat_d = mat_q;
      vec_d = vec_q;
      if (w_mat_wr) mat_d[i_wr_addr]            = i_wr_data;
      if (w_vec_wr) vec_d[i_wr_addr[COL_W-1:0]] = i_wr_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < M * N; i++) mat_q[i] <= '0;
         for (int j = 0; j < N; j++)     vec_q[j] <= '0;
      end else begin
         mat_q <= mat_d;
         vec_q <= vec_d;
      end
   end

   // Write-through: a write landing in the same cycle as the read is visible,
   // so a stream started together with a write picks up the new value.
   always_comb begin
      w_rd_idx = ADDR_W'(i_rd_row) * ADDR_W'(N) + ADDR_W'(i_rd_col);
      o_rd_k   = (w_mat_wr && (i_wr_addr == w_rd_idx)) ? i_wr_data : mat_q[w_rd_idx];
      o_rd_l   = (w_vec_wr && (i_wr_addr[COL_W-1:0] == i_rd_col)) ? i_wr_data : vec_q[i_rd_col];
   end

endmodule
`default_nettype wire

// File: rtl/matriz_operand_feeder.sv
`default_nettype none
// ============================================================================
//  Module   : matriz_operand_feeder
//  Purpose  : Streams matrix-vector operand pairs (k=A[row][col], l=x[col])
//             to a MAC over a valid/ready handshake, row by row, framing each
//             row with first/last. All outputs are registered.
//  Ports    : wr_en/wr_sel/wr_addr/wr_data  operand load (IDLE only)
//             start                         begin a stream (IDLE only)
//             busy/done                     status; done is a 1-cycle pulse
//             pair_valid/pair_ready         operand handshake
//             k/l/first/last/row            operand pair and framing
//  Revision : 1.0  initial release
// ============================================================================
module matriz_operand_feeder
   import matriz_pkg::*;
#(
   parameter int W = W_DEF,
   parameter int N = N_DEF,
   parameter int M = M_DEF,
   localparam int ADDR_W = clog2_min1(M * N),
   localparam int ROW_W  = clog2_min1(M),
   localparam int COL_W  = clog2_min1(N)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en,
   input  logic              wr_sel,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [W-1:0]      wr_data,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              pair_valid,
   input  logic              pair_ready,
   output logic [W-1:0]      k,
   output logic [W-1:0]      l,
   output logic              first,
   output logic              last,
   output logic [ROW_W-1:0]  row
);

   localparam logic [COL_W-1:0] c_col_max = COL_W'(N - 1);
   localparam logic [ROW_W-1:0] c_row_max = ROW_W'(M - 1);

   state_e             state_q, state_d;
   logic [COL_W-1:0]   col_q, col_d;
   logic [ROW_W-1:0]   row_q, row_d;
   logic               pair_valid_q, pair_valid_d;
   logic [W-1:0]       k_q, k_d;
   logic [W-1:0]       l_q, l_d;
   logic               first_q, first_d;
   logic               last_q, last_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;

   logic               w_col_wrap;
   logic [COL_W-1:0]   w_nxt_col;
   logic [ROW_W-1:0]   w_nxt_row;
   logic [ROW_W-1:0]   w_rd_row;
   logic [COL_W-1:0]   w_rd_col;
   logic [W-1:0]       w_rd_k;
   logic [W-1:0]       w_rd_l;
   logic               w_store_we;

   // Storage is only writable while idle; a stream sees a frozen snapshot.
   assign w_store_we = wr_en && (state_q == ST_IDLE);

   matriz_store #(
      .W      (W),
      .N      (N),
      .M      (M),
      .ADDR_W (ADDR_W),
      .ROW_W  (ROW_W),
      .COL_W  (COL_W)
   ) u_store (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_we      (w_store_we),
      .i_wr_sel  (wr_sel),
      .i_wr_addr (wr_addr),
      .i_wr_data (wr_data),
      .i_rd_row  (w_rd_row),
      .i_rd_col  (w_rd_col),
      .o_rd_k    (w_rd_k),
      .o_rd_l    (w_rd_l)
   );

   // The store is addressed with the pair that will be presented next, so the
   // output registers can load it on the same edge that accepts the current one.
   always_comb begin
      w_col_wrap = (col_q == c_col_max);
      w_nxt_col  = w_col_wrap ? '0 : col_q + 1'b1;
      w_nxt_row  = w_col_wrap ? row_q + 1'b1 : row_q;
      if (state_q == ST_STREAM) begin
         w_rd_row = w_nxt_row;
         w_rd_col = w_nxt_col;
      end else begin
         w_rd_row = '0;
         w_rd_col = '0;
      end
   end

   always_comb begin
      state_d      = state_q;
      col_d        = col_q;
      row_d        = row_q;
      pair_valid_d = pair_valid_q;
      k_d          = k_q;
      l_d          = l_q;
      first_d      = first_q;
      last_d       = last_q;
      busy_d       = busy_q;
      done_d       = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d      = ST_STREAM;
               col_d        = '0;
               row_d        = '0;
               pair_valid_d = 1'b1;
               busy_d       = 1'b1;
               k_d          = w_rd_k;
               l_d          = w_rd_l;
               first_d      = 1'b1;
               last_d       = (N == 1);
            end
         end
         ST_STREAM: begin
            if (pair_ready) begin
               if (w_col_wrap && (row_q == c_row_max)) begin
                  state_d      = ST_DONE;
                  col_d        = '0;
                  row_d        = '0;
                  pair_valid_d = 1'b0;
                  busy_d       = 1'b0;
                  done_d       = 1'b1;
                  k_d          = '0;
                  l_d          = '0;
                  first_d      = 1'b0;
                  last_d       = 1'b0;
               end else begin
                  col_d   = w_nxt_col;
                  row_d   = w_nxt_row;
                  k_d     = w_rd_k;
                  l_d     = w_rd_l;
                  first_d = (w_nxt_col == '0);
                  last_d  = (w_nxt_col == c_col_max);
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         col_q        <= '0;
         row_q        <= '0;
         pair_valid_q <= 1'b0;
         k_q          <= '0;
         l_q          <= '0;
         first_q      <= 1'b0;
         last_q       <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         col_q        <= col_d;
         row_q        <= row_d;
         pair_valid_q <= pair_valid_d;
         k_q          <= k_d;
         l_q          <= l_d;
         first_q      <= first_d;
         last_q       <= last_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
      end
   end

   assign busy       = busy_q;
   assign done       = done_q;
   assign pair_valid = pair_valid_q;
   assign k          = k_q;
   assign l          = l_q;
   assign first      = first_q;
   assign last       = last_q;
   assign row        = row_q;

endmodule
`default_nettype wire

// File: tb/tb_matriz_operand_feeder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_matriz_operand_feeder
//  Purpose  : Self-checking bench for matriz_operand_feeder. Expected pairs
//             and row sums are queued from a bench-side copy of A and x when
//             a stream is launched and consumed as the DUT hands pairs over.
//  Revision : 1.0  initial release
// ============================================================================
module tb_matriz_operand_feeder;

   localparam int W     = 11;
   localparam int N     = 4;
   localparam int M     = 4;
   localparam int ACC_W = 2 * W + 2;

   typedef struct packed {
      logic [W-1:0] k;
      logic [W-1:0] l;
      logic         first;
      logic         last;
      logic [1:0]   row;
   } pair_t;

   logic         clk;
   logic         rst_n;
   logic         wr_en;
   logic         wr_sel;
   logic [3:0]   wr_addr;
   logic [W-1:0] wr_data;
   logic         start;
   logic         busy;
   logic         done;
   logic         pair_valid;
   logic         pair_ready;
   logic [W-1:0] k;
   logic [W-1:0] l;
   logic         first;
   logic         last;
   logic [1:0]   row;

   matriz_operand_feeder dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .wr_en      (wr_en),
      .wr_sel     (wr_sel),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .start      (start),
      .busy       (busy),
      .done       (done),
      .pair_valid (pair_valid),
      .pair_ready (pair_ready),
      .k          (k),
      .l          (l),
      .first      (first),
      .last       (last),
      .row        (row)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int done_cnt = 0;

   logic [W-1:0] a_m [M*N];
   logic [W-1:0] x_m [N];

   pair_t       exp_q [$];
   logic [63:0] sum_q [$];

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   // ---------------- monitor: scoreboard, reference MAC, stall stability
   logic [ACC_W-1:0] acc;
   logic             hold_v;
   pair_t            held;

   always @(negedge clk) begin
      if (rst_n) begin
         if (hold_v) begin
            chk("stall_valid", pair_valid, 1);
            chk("stall_k", k, held.k);
            chk("stall_l", l, held.l);
            chk("stall_first", first, held.first);
            chk("stall_last", last, held.last);
            chk("stall_row", row, held.row);
         end
         hold_v = pair_valid && !pair_ready;
         held   = '{k: k, l: l, first: first, last: last, row: row};
         if (pair_valid && pair_ready) begin
            chk("pair_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
               pair_t e;
               e = exp_q.pop_front();
               chk("k", k, e.k);
               chk("l", l, e.l);
               chk("first", first, e.first);
               chk("last", last, e.last);
               chk("row", row, e.row);
            end
            acc = (first ? '0 : acc) + ACC_W'(k) * ACC_W'(l);
            if (last) begin
               chk("sum_expected", sum_q.size() != 0, 1);
               if (sum_q.size() != 0) chk("row_sum", acc, sum_q.pop_front());
            end
         end
         if (done) done_cnt++;
      end else begin
         hold_v = 1'b0;
      end
   end

   // ---------------- stimulus helpers
   task automatic write_op(input logic sel, input logic [3:0] addr, input logic [W-1:0] data);
      wr_en = 1'b1; wr_sel = sel; wr_addr = addr; wr_data = data;
      @(posedge clk); #1;
      wr_en = 1'b0;
   endtask

   task automatic chk_quiet(input string tag);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_valid"}, pair_valid, 0);
      chk({tag, "_k"}, k, 0);
      chk({tag, "_l"}, l, 0);
      chk({tag, "_first"}, first, 0);
      chk({tag, "_last"}, last, 0);
      chk({tag, "_row"}, row, 0);
   endtask

   // mode 0: ready=1; 1: ready toggles 0/1; 2: start pulses mid-stream and in
   // DONE; 3: write attempt to A[0][0] mid-stream. abort_at>0 resets then.
   task automatic run_stream(input int mode, input int abort_at, input int exp_done,
                             input bit sw, input logic [W-1:0] sw_val);
      int c_done;
      int d0;
      if (sw) a_m[0] = sw_val;
      for (int r = 0; r < M; r++) begin
         logic [63:0] s;
         s = 0;
         for (int c = 0; c < N; c++) begin
            exp_q.push_back('{k: a_m[r*N+c], l: x_m[c], first: (c == 0),
                              last: (c == N-1), row: 2'(r)});
            s += 64'(a_m[r*N+c]) * 64'(x_m[c]);
         end
         sum_q.push_back(s);
      end
      d0 = done_cnt;
      c_done = -1;
      start = 1'b1;
      if (sw) begin
         wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 4'd0; wr_data = sw_val;
      end
      for (int c = 1; c <= 200; c++) begin
         @(posedge clk); #1;
         if (c == abort_at) begin
            rst_n = 1'b0;
            start = 1'b0;
            wr_en = 1'b0;
            #1;
            chk_quiet("abort");
            exp_q.delete();
            sum_q.delete();
            for (int i = 0; i < M*N; i++) a_m[i] = '0;
            for (int i = 0; i < N; i++)   x_m[i] = '0;
            repeat (2) @(posedge clk);
            #1;
            rst_n = 1'b1;
            return;
         end
         start      = (mode == 2) && (c == 5 || c == exp_done);
         wr_en      = (mode == 3) && (c == 3);
         wr_sel     = 1'b0;
         wr_addr    = 4'd0;
         wr_data    = 11'd99;
         pair_ready = (mode == 1) ? (c % 2 == 0) : 1'b1;
         @(negedge clk);
         if (done) begin
            c_done = c;
            break;
         end
      end
      chk("done_cycle", c_done, exp_done);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         start = 1'b0;
         wr_en = 1'b0;
         @(negedge clk);
         chk("post_done", done, 0);
         chk("post_busy", busy, 0);
         chk("post_valid", pair_valid, 0);
      end
      chk("done_pulses", done_cnt - d0, 1);
      chk("pairs_left", exp_q.size(), 0);
   endtask

   // ---------------- main sequence
   initial begin
      rst_n = 1'b0; wr_en = 1'b0; wr_sel = 1'b0; wr_addr = '0; wr_data = '0;
      start = 1'b0; pair_ready = 1'b0; hold_v = 1'b0; acc = '0;
      for (int i = 0; i < M*N; i++) a_m[i] = '0;
      for (int i = 0; i < N; i++)   x_m[i] = '0;
      repeat (3) @(posedge clk);
      #1;
      chk_quiet("rst");
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk_quiet("idle");

      for (int i = 0; i < M*N; i++) begin
         write_op(1'b0, 4'(i), W'(i + 1));
         a_m[i] = W'(i + 1);
      end
      for (int i = 0; i < N; i++) begin
         write_op(1'b1, 4'(i), W'(i + 1));
         x_m[i] = W'(i + 1);
      end

      run_stream(0, 0, 17, 1'b0, '0);
      run_stream(1, 0, 33, 1'b0, '0);
      write_op(1'b1, 4'd5, 11'd77);
      run_stream(3, 0, 17, 1'b0, '0);
      run_stream(0, 0, 17, 1'b0, '0);
      run_stream(2, 0, 17, 1'b0, '0);
      run_stream(0, 0, 17, 1'b1, 11'd7);

      for (int i = 0; i < M*N; i++) begin
         write_op(1'b0, 4'(i), 11'd2047);
         a_m[i] = 11'd2047;
      end
      for (int i = 0; i < N; i++) begin
         write_op(1'b1, 4'(i), 11'd2047);
         x_m[i] = 11'd2047;
      end
      run_stream(0, 0, 17, 1'b0, '0);

      run_stream(0, 7, 17, 1'b0, '0);
      run_stream(0, 0, 17, 1'b0, '0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
